// File: rtl/mm_writer_pkg.sv
// Shared types and elaboration helpers for the Avalon-MM burst writer.
package mm_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // An Avalon burstcount field must be able to encode the value MAX_BURST itself.
  function automatic int burstcount_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO whose head entry is held in its own register, so downstream
// logic sees a flop output rather than a read mux.
module stream_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = head_q;
  assign count   = count_q;

  always_comb begin
    // NOTE: every _d gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
    // The head register mirrors mem[rd_ptr]; when the entry behind it is not
    // stored yet it can only be the word being pushed this cycle.
    if (do_pop) begin
      head_d = (count_q > CNT_W'(1)) ? mem[ptr_inc(rd_ptr_q)] : wr_data;
    end else if (empty && do_push) begin
      head_d = wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/avalon_mm_burst_writer.sv
// Buffers a beat stream and writes it out as Avalon-MM bursts of up to MAX_BURST
// beats to consecutive beat-aligned addresses starting at base_addr.
module avalon_mm_burst_writer
  import mm_writer_pkg::*;
#(
  parameter int BEAT_W       = 128,
  parameter int ADDR_W       = 32,
  parameter int MAX_BURST    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 32,
  parameter int BURSTCOUNT_W = burstcount_width(MAX_BURST)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [BEAT_W-1:0]       s_data,
  input  logic [BEAT_W/8-1:0]     s_strb,
  input  logic                    s_last,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        beats_written,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [BEAT_W-1:0]       avm_writedata,
  output logic [BEAT_W/8-1:0]     avm_byteenable,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest
);

  localparam int                STRB_W     = BEAT_W / 8;
  localparam int                FIFO_W     = BEAT_W + STRB_W;
  localparam int                FCNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                BYTE_SHIFT = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

  if (!is_pow2(BEAT_W) || BEAT_W < 8) begin : g_bad_beat_w
    $error("BEAT_W must be a power of 2 and at least 8");
  end
  if (!is_pow2(MAX_BURST) || MAX_BURST > 128) begin : g_bad_max_burst
    $error("MAX_BURST must be a power of 2 in 1..128");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < MAX_BURST) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least MAX_BURST");
  end
  if (BURSTCOUNT_W != burstcount_width(MAX_BURST)) begin : g_bad_bc_w
    $error("BURSTCOUNT_W is derived from MAX_BURST and must not be overridden");
  end

  logic [FIFO_W-1:0] fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BURSTCOUNT_W-1:0] bcount_q, bcount_d;
  logic [BURSTCOUNT_W-1:0] remain_q, remain_d;
  logic [BURSTCOUNT_W-1:0] launch_len;
  logic [CNT_W-1:0]        beats_q, beats_d;
  logic                    write_q, write_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    last_seen_q, last_seen_d;
  logic                    open_q, open_d;

  assign fifo_push = s_valid && s_ready;
  assign fifo_pop  = write_q && !avm_waitrequest;

  stream_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({s_strb, s_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_ready                         = !fifo_full && open_q;
  assign busy                            = busy_q;
  assign done                            = done_q;
  assign beats_written                   = beats_q;
  assign avm_address                     = addr_q;
  assign avm_write                       = write_q;
  assign avm_burstcount                  = bcount_q;
  assign {avm_byteenable, avm_writedata} = fifo_head;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bcount_d    = bcount_q;
    remain_d    = remain_q;
    beats_d     = beats_q;
    write_d     = write_q;
    last_seen_d = last_seen_q;
    open_d      = open_q;
    launch_len  = (fifo_count >= FCNT_W'(MAX_BURST)) ? BURSTCOUNT_W'(MAX_BURST)
                                                     : BURSTCOUNT_W'(fifo_count);

    if (fifo_push && s_last) begin
      last_seen_d = 1'b1;
      open_d      = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr & ALIGN_MASK;
          beats_d     = '0;
          last_seen_d = 1'b0;
          open_d      = 1'b1;
          state_d     = ARM;
        end
      end
      ARM: begin
        // A burst launches only once every one of its beats is buffered, so
        // avm_write never has to drop mid-burst for lack of data.
        if (fifo_count >= FCNT_W'(MAX_BURST) || (last_seen_q && !fifo_empty)) begin
          bcount_d = launch_len;
          remain_d = launch_len;
          write_d  = 1'b1;
          state_d  = BURST;
        end else if (last_seen_q) begin
          state_d = DONE;
        end
      end
      BURST: begin
        if (fifo_pop) begin
          if (beats_q != '1) begin
            beats_d = beats_q + CNT_W'(1);
          end
          remain_d = remain_q - BURSTCOUNT_W'(1);
          if (remain_q == BURSTCOUNT_W'(1)) begin
            write_d = 1'b0;
            addr_d  = addr_q + (ADDR_W'(bcount_q) << BYTE_SHIFT);
            state_d = ARM;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      bcount_q    <= '0;
      remain_q    <= '0;
      beats_q     <= '0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_seen_q <= 1'b0;
      open_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bcount_q    <= bcount_d;
      remain_q    <= remain_d;
      beats_q     <= beats_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_seen_q <= last_seen_d;
      open_q      <= open_d;
    end
  end

`ifdef SIMULATION
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (avm_write && avm_waitrequest) |=> (avm_write && $stable(avm_address) &&
      $stable(avm_burstcount) && $stable(avm_writedata) && $stable(avm_byteenable)));

  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    ((avm_address & ~ALIGN_MASK) == '0));
`endif

endmodule

// File: tb/tb_avalon_mm_burst_writer.sv
// Scoreboard bench for avalon_mm_burst_writer: expected beats and bursts are queued
// as stimulus is driven and popped as the slave side accepts writes.
module tb_avalon_mm_burst_writer;

  localparam int BEAT_W    = 128;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 32;
  localparam int BC_W      = $clog2(MAX_BURST) + 1;
  localparam int BYTES     = BEAT_W / 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                len;
  } burst_t;

  logic                 clk;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [BEAT_W-1:0]    s_data;
  logic [BYTES-1:0]     s_strb;
  logic                 s_last;
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     beats_written;
  logic [ADDR_W-1:0]    avm_address;
  logic                 avm_write;
  logic [BEAT_W-1:0]    avm_writedata;
  logic [BYTES-1:0]     avm_byteenable;
  logic [BC_W-1:0]      avm_burstcount;
  logic                 avm_waitrequest;

  avalon_mm_burst_writer #(
    .BEAT_W     (BEAT_W),
    .ADDR_W     (ADDR_W),
    .MAX_BURST  (MAX_BURST),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_strb          (s_strb),
    .s_last          (s_last),
    .start           (start),
    .base_addr       (base_addr),
    .busy            (busy),
    .done            (done),
    .beats_written   (beats_written),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_burstcount  (avm_burstcount),
    .avm_waitrequest (avm_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [BYTES+BEAT_W-1:0] exp_beats[$];
  burst_t                  exp_bursts[$];

  int acc_cnt     = 0;
  int done_cnt    = 0;
  int src_acc     = 0;
  int wr_mode     = 0;
  int stall_timer = 0;
  int stall_left  = 0;
  int stalled_idx = -1;

  // Slave model: drives waitrequest according to the current stall mode.
  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wr_mode == 2) begin
        avm_waitrequest = (stall_timer > 0);
        if (stall_timer > 0) stall_timer--;
      end else if (wr_mode == 1) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else if (avm_write && acc_cnt[0] && stalled_idx != acc_cnt) begin
          stalled_idx     = acc_cnt;
          avm_waitrequest = 1'b1;
          stall_left      = 2;
        end else begin
          avm_waitrequest = 1'b0;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: sampled on the falling edge, ahead of the edge that accepts a beat.
  initial begin : monitor
    int                      left;
    bit                      hold_v;
    logic [ADDR_W-1:0]       h_addr;
    logic [BEAT_W-1:0]       h_data;
    logic [BYTES-1:0]        h_strb;
    logic [BC_W-1:0]         h_bc;
    logic [ADDR_W-1:0]       cur_addr;
    burst_t                  b;
    logic [BYTES+BEAT_W-1:0] e;
    left   = 0;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_beats.delete();
        exp_bursts.delete();
        left   = 0;
        hold_v = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (hold_v) begin
          check("stall_write", avm_write, 1'b1);
          check("stall_addr", avm_address, h_addr);
          check("stall_data", avm_writedata, h_data);
          check("stall_strb", avm_byteenable, h_strb);
          check("stall_bc", avm_burstcount, h_bc);
        end
        hold_v = avm_write && avm_waitrequest;
        h_addr = avm_address;
        h_data = avm_writedata;
        h_strb = avm_byteenable;
        h_bc   = avm_burstcount;
        if (avm_write && !avm_waitrequest) begin
          if (left == 0) begin
            if (exp_bursts.size() == 0) begin
              check("burst_unexpected", 1'b1, 1'b0);
              left = int'(avm_burstcount);
            end else begin
              b = exp_bursts.pop_front();
              check("burst_addr", avm_address, b.addr);
              check("burst_len", avm_burstcount, b.len);
              left = b.len;
            end
            cur_addr = avm_address;
          end else begin
            check("burst_addr_hold", avm_address, cur_addr);
          end
          if (exp_beats.size() == 0) begin
            check("beat_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_beats.pop_front();
            check("beat_data_strb", {avm_byteenable, avm_writedata}, e);
          end
          if (left > 0) left--;
          acc_cnt++;
        end
      end
    end
  end

  task automatic push_bursts(input logic [ADDR_W-1:0] base, input int n);
    burst_t b;
    logic [ADDR_W-1:0] a;
    int rem;
    a   = base & ~ADDR_W'(BYTES - 1);
    rem = n;
    while (rem > 0) begin
      b.len  = (rem > MAX_BURST) ? MAX_BURST : rem;
      b.addr = a;
      exp_bursts.push_back(b);
      a   = a + ADDR_W'(b.len * BYTES);
      rem = rem - b.len;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_beats(input int n, input int gap_after, input int gap_len);
    logic [BEAT_W-1:0] d;
    logic [BYTES-1:0]  st;
    bit ok;
    int guard;
    for (int i = 0; i < n; i++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      st = BYTES'($urandom);
      s_valid = 1'b1;
      s_data  = d;
      s_strb  = st;
      s_last  = (i == n - 1);
      ok    = 1'b0;
      guard = 0;
      while (!ok && guard < 500) begin
        @(negedge clk);
        ok = s_ready;
        @(posedge clk); #1;
        guard++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) begin
        check("src_timeout", 1'b0, 1'b1);
        return;
      end
      exp_beats.push_back({st, d});
      src_acc++;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check("gap_no_write", avm_write, 1'b0);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int n, input int d0);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1'b1);
    if (got) begin
      check("busy_at_done", busy, 1'b1);
      check("beats_written", beats_written, n);
      @(negedge clk);
      check("busy_after_done", busy, 1'b0);
      check("done_one_cycle", done, 1'b0);
      check("beats_hold", beats_written, n);
      check("done_pulses", done_cnt - d0, 1);
    end
    check("beats_drained", exp_beats.size(), 0);
    check("bursts_drained", exp_bursts.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_transfer(input logic [ADDR_W-1:0] base, input int n,
                              input int gap_after, input int gap_len);
    int d0;
    d0 = done_cnt;
    push_bursts(base, n);
    pulse_start(base);
    send_beats(n, gap_after, gap_len);
    wait_done(n, d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a0;
    int d0;
    bit got;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_strb    = '0;
    s_last    = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_addr", avm_address, 32'h0);
    check("rst_bc", avm_burstcount, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_beats", beats_written, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain stream: 4+4+2 bursts from 0x1000
    wr_mode = 0;
    run_transfer(32'h1000, 10, -1, 0);

    // Same stream with a 3-cycle slave stall on every second beat
    wr_mode = 1;
    run_transfer(32'h1000, 10, -1, 0);
    wr_mode = 0;

    // Single beat, misaligned base
    run_transfer(32'h2008, 1, -1, 0);

    // Source pauses after the 3rd of 4 beats
    run_transfer(32'h5000, 4, 2, 5);

    // Long slave stall with 12 beats offered: FIFO must fill and back-pressure
    a0          = src_acc;
    stall_timer = 40;
    wr_mode     = 2;
    fork
      run_transfer(32'h4000, 12, -1, 0);
      begin
        repeat (30) @(negedge clk);
        check("full_s_ready", s_ready, 1'b0);
        check("full_accepted", src_acc - a0, DEPTH);
        check("full_write_held", avm_write, 1'b1);
      end
    join
    wr_mode = 0;

    // Reset in the middle of a 4-beat burst
    d0 = done_cnt;
    push_bursts(32'h3000, 4);
    pulse_start(32'h3000);
    send_beats(4, -1, 0);
    a0  = acc_cnt;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (acc_cnt - a0 >= 2) got = 1'b1;
    end
    check("mid_two_beats", got, 1'b1);
    check("mid_beats_written", beats_written, 2);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_write", avm_write, 1'b0);
    check("async_rst_addr", avm_address, 32'h0);
    check("async_rst_bc", avm_burstcount, 0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_beats", beats_written, 0);
    check("async_rst_s_ready", s_ready, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_transfer(32'h0, 3, -1, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_mm_burst_writer.md
Name: avalon_mm_burst_writer

Overview:
Parametrised successor to the single-beat Avalon-MM stream writer. It buffers an incoming beat stream in an internal FIFO and issues Avalon-MM write bursts of up to MAX_BURST beats to consecutive, beat-aligned addresses starting at base_addr. Sits between the result packer and the SDRAM/HPS bridge in the matrix-multiply datapath. It reports the beats written and pulses done once the last beat is accepted by the slave.

Parameters:
BEAT_W, 128, data width in bits (power of 2, ≥8)
ADDR_W, 32, byte address width
MAX_BURST, 8, maximum beats per burst (power of 2, 1..128)
FIFO_DEPTH, 16, buffer depth in beats (power of 2, ≥ MAX_BURST)
CNT_W, 32, width of beats_written counter
BURSTCOUNT_W, $clog2(MAX_BURST)+1, derived; not for override

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_valid  in  1  stream beat valid
s_ready  out  1  stream beat accepted when s_valid && s_ready
s_data  in  BEAT_W  beat data
s_strb  in  BEAT_W/8  beat byte enables
s_last  in  1  final beat of transfer
start  in  1  pulse: begin transfer; ignored unless idle
base_addr  in  ADDR_W  byte base address; low log2(BEAT_W/8) bits forced to 0
busy  out  1  high from start until done pulse inclusive
done  out  1  one-cycle pulse when the transfer completes
beats_written  out  CNT_W  beats accepted by slave this transfer; holds after done
avm_address  out  ADDR_W  burst start byte address
avm_write  out  1  write request
avm_writedata  out  BEAT_W  write data
avm_byteenable  out  BEAT_W/8  byte enables
avm_burstcount  out  BURSTCOUNT_W  beats in current burst
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO flushed, s_ready=0, avm_write=0, avm_address=0, avm_burstcount=0, busy=0, done=0, beats_written=0. Reset mid-burst abandons the burst; no further writes are issued.
- FIFO: push on s_valid&&s_ready; pop on avm_write&&!avm_waitrequest. Writedata and byteenable come from the FIFO head, registered. Simultaneous push and pop is allowed unless the FIFO is full, where push is blocked.
- s_ready = !fifo_full && stream_open. stream_open is set on accepted start and cleared on the cycle after a beat with s_last is accepted.
- States:
  - IDLE: on start, latch aligned base_addr, clear beats_written and last_seen, set stream_open, go to ARM. busy is asserted the next cycle.
  - ARM: launch a burst when fifo_count ≥ MAX_BURST (len=MAX_BURST), or when last_seen && fifo_count>0 (len=min(fifo_count,MAX_BURST)). Go to DONE when last_seen && fifo_count==0. Otherwise wait.
  - BURST: avm_write=1 continuously, because a burst launches only with all of its beats buffered. avm_address and avm_burstcount are held constant for the whole burst. While waitrequest=1, all avm outputs are held stable. Each accepted beat increments beats_written and decrements the remaining count. After the final beat of the burst: address += len*BEAT_W/8 (wraps modulo 2^ADDR_W), return to ARM.
  - DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- Latency: with no waitrequest, the first avm_write asserts 2 cycles after the MAX_BURST-th beat is pushed. ARM→BURST costs one cycle per burst.
- start while not IDLE: ignored.
- s_last on the first beat: one-beat burst.
- s_valid with s_ready=0 (closed or full): no effect.
- Zero-beat transfers are not supported; start must be followed by at least one beat carrying s_last.
- beats_written saturates at 2^CNT_W-1.

Decomposition:
- Package mm_writer_pkg: state_t enum (IDLE, ARM, BURST, DONE) and the function clog2-based BURSTCOUNT_W helper.
- Sub-module stream_fifo (DATA_W=BEAT_W+BEAT_W/8, DEPTH=FIFO_DEPTH): registered head output, count, full and empty outputs, same clk/rst.
- Elaboration assertions: FIFO_DEPTH ≥ MAX_BURST; powers of 2.
- SVA under SIMULATION:
  - avm outputs are stable while avm_write && avm_waitrequest.
  - avm_address is beat-aligned.

Test Plan:
- BEAT_W=128, MAX_BURST=4, FIFO_DEPTH=8, base 0x1000, 10 beats, no waitrequest -> bursts (0x1000,4), (0x1040,4), (0x1080,2); beats_written=10; one done pulse.
- Same config, waitrequest high 3 cycles on every 2nd beat -> avm outputs stable during stalls; data order and strobes match input exactly; beats_written=10.
- Single beat with s_last, base 0x2008 -> address forced to 0x2000, burstcount=1, done pulses, busy low the following cycle.
- Source stalls (s_valid low 5 cycles after beat 3 of 4) -> no write issued until the 4th beat is buffered; one burst of 4.
- Slave stalls for 40 cycles with 12 beats offered -> FIFO fills to 8, s_ready=0 while full, no beat lost or duplicated.
- rst asserted mid-burst (after 2 of 4 beats) -> all outputs return to reset values asynchronously; a subsequent start with base 0x0 writes correctly from beats_written=0.
